// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the ID/EX stage register and its hazard detector.
package pipeline_pkg;

    localparam int unsigned DATA_W_DFLT     = 32;
    localparam int unsigned REG_ADDR_W_DFLT = 5;
    localparam int unsigned BUBBLE_CNT_W    = 16;

    typedef struct packed {
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       MemtoReg;
        logic       ALUSrc;
        logic       RegDst;
        logic [1:0] ALUOp;
    } ctrl_t;

    localparam ctrl_t      CTRL_NOP = '0;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is a source of the instruction in ID.
module load_use_detect
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DFLT
) (
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    output logic                  hazard_o
);

    // Writes to $0 are discarded, so a load targeting it never needs a bubble.
    assign hazard_o = ex_valid_i && ex_mem_read_i
                   && (ex_rt_i != REG_ADDR_W'(REG_ZERO))
                   && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage_reg
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DFLT,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DFLT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall_in,
    input  logic                    flush,
    input  logic                    ID_RegWrite,
    input  logic                    ID_MemRead,
    input  logic                    ID_MemWrite,
    input  logic                    ID_MemtoReg,
    input  logic                    ID_ALUSrc,
    input  logic                    ID_RegDst,
    input  logic [1:0]              ID_ALUOp,
    input  logic [DATA_W-1:0]       ID_ReadData1,
    input  logic [DATA_W-1:0]       ID_ReadData2,
    input  logic [DATA_W-1:0]       ID_SignExtImm,
    input  logic [REG_ADDR_W-1:0]   IF_ID_RegisterRs,
    input  logic [REG_ADDR_W-1:0]   IF_ID_RegisterRt,
    input  logic [REG_ADDR_W-1:0]   IF_ID_RegisterRd,
    output logic                    ID_EX_RegWrite,
    output logic                    ID_EX_MemRead,
    output logic                    ID_EX_MemWrite,
    output logic                    ID_EX_MemtoReg,
    output logic                    ID_EX_ALUSrc,
    output logic                    ID_EX_RegDst,
    output logic [1:0]              ID_EX_ALUOp,
    output logic [DATA_W-1:0]       ID_EX_ReadData1,
    output logic [DATA_W-1:0]       ID_EX_ReadData2,
    output logic [DATA_W-1:0]       ID_EX_SignExtImm,
    output logic [REG_ADDR_W-1:0]   ID_EX_RegisterRs,
    output logic [REG_ADDR_W-1:0]   ID_EX_RegisterRt,
    output logic [REG_ADDR_W-1:0]   ID_EX_RegisterRd,
    output logic                    ID_EX_Valid,
    output logic                    stall_ID,
    output logic [BUBBLE_CNT_W-1:0] bubble_count
);

    ctrl_t                 ctrl_d, ctrl_q, id_ctrl;
    logic [DATA_W-1:0]     rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
    logic [REG_ADDR_W-1:0] rs_d, rs_q, rt_d, rt_q, rdst_d, rdst_q;
    logic                  valid_d, valid_q;
    logic                  hazard;

    assign id_ctrl = '{RegWrite: ID_RegWrite, MemRead: ID_MemRead, MemWrite: ID_MemWrite,
                       MemtoReg: ID_MemtoReg, ALUSrc: ID_ALUSrc, RegDst: ID_RegDst,
                       ALUOp: ID_ALUOp};

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.MemRead),
        .ex_rt_i       (rt_q),
        .id_rs_i       (IF_ID_RegisterRs),
        .id_rt_i       (IF_ID_RegisterRt),
        .hazard_o      (hazard)
    );

    assign stall_ID = (hazard || stall_in) && !flush;

    // Flush and bubble both produce an all-zero NOP; stall_in holds everything.
    always_comb begin
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rdst_d  = rdst_q;
        valid_d = valid_q;
        if (flush || (!stall_in && hazard)) begin
            ctrl_d  = CTRL_NOP;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
            rdst_d  = '0;
            valid_d = 1'b0;
        end else if (!stall_in) begin
            ctrl_d  = id_ctrl;
            rd1_d   = ID_ReadData1;
            rd2_d   = ID_ReadData2;
            imm_d   = ID_SignExtImm;
            rs_d    = IF_ID_RegisterRs;
            rt_d    = IF_ID_RegisterRt;
            rdst_d  = IF_ID_RegisterRd;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= CTRL_NOP;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rdst_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rdst_q  <= rdst_d;
            valid_q <= valid_d;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic                    bubble;
    logic [BUBBLE_CNT_W-1:0] cnt_d, cnt_q;

    assign bubble = hazard && !stall_in && !flush;

    always_comb begin
        cnt_d = cnt_q;
        if (bubble && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_count = cnt_q;
`else
    assign bubble_count = '0;
`endif

    assign ID_EX_RegWrite   = ctrl_q.RegWrite;
    assign ID_EX_MemRead    = ctrl_q.MemRead;
    assign ID_EX_MemWrite   = ctrl_q.MemWrite;
    assign ID_EX_MemtoReg   = ctrl_q.MemtoReg;
    assign ID_EX_ALUSrc     = ctrl_q.ALUSrc;
    assign ID_EX_RegDst     = ctrl_q.RegDst;
    assign ID_EX_ALUOp      = ctrl_q.ALUOp;
    assign ID_EX_ReadData1  = rd1_q;
    assign ID_EX_ReadData2  = rd2_q;
    assign ID_EX_SignExtImm = imm_q;
    assign ID_EX_RegisterRs = rs_q;
    assign ID_EX_RegisterRt = rt_q;
    assign ID_EX_RegisterRd = rdst_q;
    assign ID_EX_Valid      = valid_q;

endmodule
